// File: rtl/i2c_target_multi.sv
// i2c_target_multi: split-bus I2C target with START/STOP/repeated-START
// detection, DATA_BYTES-byte write and read transfers and per-byte ACK/NACK.
// Optional feature macro: I2C_TGT_GENCALL_EN (ACK general-call write 0x00).
module i2c_target_multi #(
  parameter int unsigned DATA_BYTES = 2,
  parameter logic [6:0]  ADDR_RST   = 7'h00
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              I2C_ADDR,
  input  logic [8*DATA_BYTES-1:0] RD_DATA,
  input  logic                    SCL,
  input  logic                    SDA_OUT,
  input  logic                    SDA_OE,
  output logic                    SDA_IN,
  output logic [8*DATA_BYTES-1:0] WR_DATA,
  output logic                    WR_VALID,
  output logic                    RD_REQ,
  output logic                    BUSY
);

  localparam int unsigned   PW   = 8 * DATA_BYTES;
  localparam int unsigned   BW   = $clog2(DATA_BYTES + 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_BYTES - 1);
  localparam logic [BW-1:0] FULL = BW'(DATA_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WR_ACK, S_READ, S_RD_ACK, S_WAIT_STOP
  } state_t;

  state_t          state, state_nxt;
  logic            scl_q, sda_q;
  logic [7:0]      shift, shift_nxt;
  logic [2:0]      bit_cnt, bit_nxt;
  logic [BW-1:0]   byte_cnt, byte_nxt;
  logic            rw, rw_nxt;
  logic [6:0]      addr_lat, addr_nxt;
  logic [PW-1:0]   rd_buf, rd_buf_nxt;
  logic [PW-1:0]   wr_buf, wr_buf_nxt;
  logic [PW-1:0]   wr_data_nxt;
  logic            sda_nxt, wr_valid_nxt, rd_req_nxt, busy_nxt;

  logic            rise_c, fall_c, start_c, stop_c, addr_hit_c, rd_bit_c;
  logic [7:0]      full_c, rd_byte_c;
  logic [PW-1:0]   wr_next_c;

  // Register bus lines once so edges and conditions can be decoded
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= SCL;
      sda_q <= SDA_OUT;
    end
  end

  assign rise_c  = SCL & ~scl_q;
  assign fall_c  = ~SCL & scl_q;
  assign start_c = SDA_OE & SCL & sda_q & ~SDA_OUT;
  assign stop_c  = SDA_OE & SCL & ~sda_q & SDA_OUT;
  assign full_c  = {shift[6:0], SDA_OUT};

`ifdef I2C_TGT_GENCALL_EN
  assign addr_hit_c = (full_c[7:1] == 7'h00) ? ~full_c[0] : (full_c[7:1] == addr_lat);
`else
  assign addr_hit_c = (full_c[7:1] != 7'h00) && (full_c[7:1] == addr_lat);
`endif

  // Select the read byte being served and merge the received write byte
  always_comb begin
    rd_byte_c = 8'hFF;
    wr_next_c = wr_buf;
    for (int unsigned k = 0; k < DATA_BYTES; k++) begin
      if (byte_cnt == BW'(k)) begin
        rd_byte_c                = rd_buf[PW-1-8*k -: 8];
        wr_next_c[PW-1-8*k -: 8] = shift;
      end
    end
  end

  assign rd_bit_c = rd_byte_c[3'd7 - bit_cnt];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; conditions override bit-level progress
  always_comb begin
    state_nxt = state;
    if (start_c) begin
      state_nxt = S_ADDR;
    end else if (stop_c) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_ADDR:     if (rise_c && bit_cnt == 3'd7) state_nxt = addr_hit_c ? S_ADDR_ACK : S_WAIT_STOP;
        S_ADDR_ACK: if (rise_c) state_nxt = rw ? S_READ : S_WRITE;
        S_WRITE:    if (rise_c && bit_cnt == 3'd7) state_nxt = S_WR_ACK;
        S_WR_ACK:   if (rise_c) state_nxt = SDA_IN ? S_WAIT_STOP : S_WRITE;
        S_READ:     if (rise_c && bit_cnt == 3'd7) state_nxt = S_RD_ACK;
        S_RD_ACK:   if (rise_c) state_nxt = (!SDA_OUT && byte_cnt < LAST) ? S_READ : S_WAIT_STOP;
        default:    ;
      endcase
    end
  end

  // Output and datapath next values
  always_comb begin
    sda_nxt      = SDA_IN;
    wr_valid_nxt = 1'b0;
    rd_req_nxt   = 1'b0;
    busy_nxt     = (state_nxt != S_IDLE);
    wr_data_nxt  = WR_DATA;
    shift_nxt    = shift;
    bit_nxt      = bit_cnt;
    byte_nxt     = byte_cnt;
    rw_nxt       = rw;
    addr_nxt     = addr_lat;
    rd_buf_nxt   = rd_buf;
    wr_buf_nxt   = wr_buf;
    if (start_c || stop_c) begin
      sda_nxt  = 1'b1;
      bit_nxt  = 3'd0;
      byte_nxt = '0;
    end else begin
      case (state)
        S_IDLE: begin
          addr_nxt = I2C_ADDR;
          sda_nxt  = 1'b1;
        end
        S_ADDR: begin
          if (rise_c) begin
            shift_nxt = full_c;
            bit_nxt   = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7 && addr_hit_c) begin
              rw_nxt = full_c[0];
              if (full_c[0]) begin
                rd_req_nxt = 1'b1;
                rd_buf_nxt = RD_DATA;
              end
            end
          end
        end
        S_ADDR_ACK: if (fall_c) sda_nxt = 1'b0;
        S_WRITE: begin
          if (fall_c) sda_nxt = 1'b1;
          if (rise_c) begin
            shift_nxt = full_c;
            bit_nxt   = bit_cnt + 3'd1;
          end
        end
        S_WR_ACK: begin
          if (fall_c) begin
            if (byte_cnt < FULL) begin
              sda_nxt    = 1'b0;
              wr_buf_nxt = wr_next_c;
              byte_nxt   = byte_cnt + BW'(1);
              if (byte_cnt == LAST) begin
                wr_data_nxt  = wr_next_c;
                wr_valid_nxt = 1'b1;
              end
            end else begin
              sda_nxt = 1'b1;
            end
          end
        end
        S_READ: begin
          if (fall_c) sda_nxt = rd_bit_c;
          if (rise_c) bit_nxt = bit_cnt + 3'd1;
        end
        S_RD_ACK: begin
          if (fall_c) sda_nxt = 1'b1;
          if (rise_c && !SDA_OUT && byte_cnt < LAST) byte_nxt = byte_cnt + BW'(1);
        end
        default: sda_nxt = 1'b1;
      endcase
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      SDA_IN   <= 1'b1;
      WR_DATA  <= '0;
      WR_VALID <= 1'b0;
      RD_REQ   <= 1'b0;
      BUSY     <= 1'b0;
      shift    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      rw       <= 1'b0;
      addr_lat <= ADDR_RST;
      rd_buf   <= '0;
      wr_buf   <= '0;
    end else begin
      SDA_IN   <= sda_nxt;
      WR_DATA  <= wr_data_nxt;
      WR_VALID <= wr_valid_nxt;
      RD_REQ   <= rd_req_nxt;
      BUSY     <= busy_nxt;
      shift    <= shift_nxt;
      bit_cnt  <= bit_nxt;
      byte_cnt <= byte_nxt;
      rw       <= rw_nxt;
      addr_lat <= addr_nxt;
      rd_buf   <= rd_buf_nxt;
      wr_buf   <= wr_buf_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_target_multi.sv
// Self-checking bench for i2c_target_multi (DATA_BYTES = 2, own address 0x2A).
module tb_i2c_target_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  i2c_addr;
  logic [15:0] rd_data;
  logic        scl, sda_out, sda_oe;
  logic        sda_in;
  logic [15:0] wr_data;
  logic        wr_valid, rd_req, busy;

  int checks = 0;
  int failures = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;
  logic sda_low_seen = 1'b0;

  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];

  i2c_target_multi #(.DATA_BYTES(2), .ADDR_RST(7'h00)) dut (
    .clk(clk), .rst(rst), .I2C_ADDR(i2c_addr), .RD_DATA(rd_data),
    .SCL(scl), .SDA_OUT(sda_out), .SDA_OE(sda_oe), .SDA_IN(sda_in),
    .WR_DATA(wr_data), .WR_VALID(wr_valid), .RD_REQ(rd_req), .BUSY(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: write payloads are compared whenever the target reports one
  always @(negedge clk) begin
    if (rst) begin
      if (wr_valid) begin
        wr_pulses++;
        if (exp_wr.size() == 0) check("wr_valid_unexpected", 32'(wr_valid), 32'd0);
        else                    check("wr_data_on_valid", 32'(wr_data), 32'(exp_wr.pop_front()));
      end
      if (rd_req)  rd_pulses++;
      if (!sda_in) sda_low_seen = 1'b1;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    if (scl == 1'b0) begin
      sda_out = 1'b1; wait_clks(4);
      scl = 1'b1;     wait_clks(4);
    end
    sda_out = 1'b0; wait_clks(4);
    scl = 1'b0;     wait_clks(1);
  endtask

  task automatic bus_stop();
    sda_out = 1'b0; wait_clks(4);
    scl = 1'b1;     wait_clks(4);
    sda_out = 1'b1; wait_clks(4);
  endtask

  task automatic clock_bit(input logic d, output logic seen);
    sda_out = d; wait_clks(4);
    scl = 1'b1;  wait_clks(3);
    seen = sda_in;
    wait_clks(1);
    scl = 1'b0;  wait_clks(1);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic x;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], x);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_check(input logic ctrl_ack, input string tag);
    logic       x;
    logic [7:0] b;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, x);
      b[i] = x;
    end
    clock_bit(ctrl_ack, x);
    if (exp_rd.size() == 0) check({tag, "_no_expect"}, 32'(exp_rd.size()), 32'd1);
    else                    check(tag, 32'(b), 32'(exp_rd.pop_front()));
  endtask

  initial begin
    logic a;
    int   w0, r0;
    rst = 1'b0; scl = 1'b1; sda_out = 1'b1; sda_oe = 1'b1;
    i2c_addr = 7'h2A; rd_data = 16'hBEEF;
    wait_clks(3);
    check("rst_sda_in",   32'(sda_in),   32'd1);
    check("rst_wr_data",  32'(wr_data),  32'd0);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_rd_req",   32'(rd_req),   32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    rst = 1'b1;
    wait_clks(3);

    // Full write: 0x54, 0xA5, 0x3C
    w0 = wr_pulses;
    exp_wr.push_back(16'hA53C);
    bus_start();
    check("w1_busy_after_start", 32'(busy), 32'd1);
    send_byte(8'h54, a); check("w1_addr_ack", 32'(a), 32'd0);
    send_byte(8'hA5, a); check("w1_d0_ack",   32'(a), 32'd0);
    send_byte(8'h3C, a); check("w1_d1_ack",   32'(a), 32'd0);
    bus_stop();
    check("w1_busy_after_stop", 32'(busy), 32'd0);
    check("w1_wr_data", 32'(wr_data), 32'h0000A53C);
    check("w1_wr_pulses", 32'(wr_pulses - w0), 32'd1);

    // Read 0x55 with payload captured at RD_REQ
    r0 = rd_pulses;
    rd_data = 16'hBEEF;
    exp_rd.push_back(8'hBE); exp_rd.push_back(8'hEF);
    bus_start();
    send_byte(8'h55, a); check("r1_addr_ack", 32'(a), 32'd0);
    check("r1_rd_req_pulses", 32'(rd_pulses - r0), 32'd1);
    rd_data = 16'h0000;
    read_check(1'b0, "r1_byte0");
    read_check(1'b1, "r1_byte1");
    check("r1_sda_released", 32'(sda_in), 32'd1);
    check("r1_busy_before_stop", 32'(busy), 32'd1);
    bus_stop();
    check("r1_busy_after_stop", 32'(busy), 32'd0);
    check("r1_rd_req_total", 32'(rd_pulses - r0), 32'd1);

    // Foreign address 0x56 is NACKed and the target stays silent
    w0 = wr_pulses; r0 = rd_pulses;
    sda_low_seen = 1'b0;
    bus_start();
    send_byte(8'h56, a); check("n1_addr_nack", 32'(a), 32'd1);
    send_byte(8'h12, a); check("n1_data_nack", 32'(a), 32'd1);
    bus_stop();
    check("n1_sda_never_low", 32'(sda_low_seen), 32'd0);
    check("n1_busy", 32'(busy), 32'd0);
    check("n1_no_rd_req", 32'(rd_pulses - r0), 32'd0);
    check("n1_no_wr_valid", 32'(wr_pulses - w0), 32'd0);

    // Short write leaves the payload untouched
    w0 = wr_pulses;
    bus_start();
    send_byte(8'h54, a); check("s1_addr_ack", 32'(a), 32'd0);
    send_byte(8'h11, a); check("s1_d0_ack",   32'(a), 32'd0);
    bus_stop();
    check("s1_wr_data_kept", 32'(wr_data), 32'h0000A53C);
    check("s1_no_wr_valid", 32'(wr_pulses - w0), 32'd0);

    // Overlong write, then repeated START into a read
    exp_wr.push_back(16'h1122);
    bus_start();
    send_byte(8'h54, a); check("o1_addr_ack", 32'(a), 32'd0);
    send_byte(8'h11, a); check("o1_d0_ack",   32'(a), 32'd0);
    send_byte(8'h22, a); check("o1_d1_ack",   32'(a), 32'd0);
    send_byte(8'h33, a); check("o1_extra_nack", 32'(a), 32'd1);
    check("o1_wr_data", 32'(wr_data), 32'h00001122);
    rd_data = 16'hCAFE;
    exp_rd.push_back(8'hCA); exp_rd.push_back(8'hFE);
    bus_start();
    check("o1_busy_rep_start", 32'(busy), 32'd1);
    send_byte(8'h55, a); check("o1_rd_addr_ack", 32'(a), 32'd0);
    read_check(1'b0, "o1_byte0");
    read_check(1'b1, "o1_byte1");
    bus_stop();
    check("o1_busy_after_stop", 32'(busy), 32'd0);

    // Asynchronous reset while the target drives a 0 data bit
    rd_data = 16'hBEEF;
    bus_start();
    send_byte(8'h55, a); check("x1_addr_ack", 32'(a), 32'd0);
    clock_bit(1'b1, a);
    check("x1_pre_sda_low", 32'(sda_in), 32'd0);
    check("x1_pre_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("x1_rst_sda_in", 32'(sda_in), 32'd1);
    check("x1_rst_busy",   32'(busy),   32'd0);
    check("x1_rst_wr_data", 32'(wr_data), 32'd0);
    scl = 1'b1; sda_out = 1'b1;
    wait_clks(2);
    rst = 1'b1;
    wait_clks(2);
    exp_wr.push_back(16'h7788);
    bus_start();
    send_byte(8'h54, a); check("x1_w_addr_ack", 32'(a), 32'd0);
    send_byte(8'h77, a); check("x1_w_d0_ack",   32'(a), 32'd0);
    send_byte(8'h88, a); check("x1_w_d1_ack",   32'(a), 32'd0);
    bus_stop();
    check("x1_wr_data", 32'(wr_data), 32'h00007788);

    // General-call address
    w0 = wr_pulses;
`ifdef I2C_TGT_GENCALL_EN
    exp_wr.push_back(16'h1234);
    bus_start();
    send_byte(8'h00, a); check("g1_gc_ack", 32'(a), 32'd0);
    send_byte(8'h12, a); check("g1_d0_ack", 32'(a), 32'd0);
    send_byte(8'h34, a); check("g1_d1_ack", 32'(a), 32'd0);
    bus_stop();
    check("g1_wr_data", 32'(wr_data), 32'h00001234);
    check("g1_wr_pulses", 32'(wr_pulses - w0), 32'd1);
    bus_start();
    send_byte(8'h01, a); check("g1_gc_read_nack", 32'(a), 32'd1);
    bus_stop();
`else
    bus_start();
    send_byte(8'h00, a); check("g1_gc_nack", 32'(a), 32'd1);
    bus_stop();
    check("g1_no_wr_valid", 32'(wr_pulses - w0), 32'd0);
    check("g1_wr_data_kept", 32'(wr_data), 32'h00007788);
`endif

    wait_clks(4);
    check("sb_wr_drained", 32'(exp_wr.size()), 32'd0);
    check("sb_rd_drained", 32'(exp_rd.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
